task_answer_tx: RTL

TASK_ANSWER_TX -- requirements
Module: task_answer_tx

---
 rtl/task_answer_pkg.sv | 19 +
 rtl/task_answer_skid.sv | 58 +++++
 rtl/task_answer_tx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/task_answer_pkg.sv
// task_answer_pkg: types and constants shared by the task-answer transmit path.
//   state_t    - framing FSM states
//   HDR_BYTES  - number of size-header bytes in front of the payload
//   PAD_BYTE   - filler emitted for payload bytes lost to an upstream underrun
package task_answer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_HI  = 3'd1,
        HDR_LO  = 3'd2,
        PAYLOAD = 3'd3,
        CHK     = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int unsigned HDR_BYTES = 2;
    localparam logic [7:0]  PAD_BYTE  = 8'h00;

endpackage

// File: rtl/task_answer_skid.sv
// task_answer_skid: 2-entry FIFO decoupling upstream read latency from the
// downstream handshake. Head entry is presented while the FIFO is non-empty.
//   i_clk, i_rst  clock and synchronous active-high reset
//   i_wr_en       write i_wr_data (ignored only if full with no read)
//   i_rd_en       pop the head entry (ignored when empty)
//   o_rd_data     head entry, zero when empty
//   o_count       occupancy 0..2
module task_answer_skid #(
    parameter int W = 9
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [0:1];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_wr;
    logic         w_rd;

    assign w_rd = i_rd_en && (r_count != 2'd0);
    // A simultaneous pop frees the slot, so a write into a full FIFO is legal then.
    assign w_wr = i_wr_en && ((r_count != 2'd2) || w_rd);

    // Storage, pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_rd) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
    assign o_count   = r_count;

endmodule

// File: rtl/task_answer_tx.sv
// task_answer_tx: frames one upstream packet as
//   [size_hi][size_lo][payload x size][checksum, optional]
// on a valid/ready byte stream, reading payload from an upstream FIFO with
// one-cycle read latency through a 2-entry skid buffer.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_tanswer_ready           upstream holds a complete packet
//   i_packet_size_in_bytes    payload length, valid with i_tanswer_ready
//   i_tdata                   upstream read data, one cycle after a request
//   o_tmanager_ready          upstream read request (one byte per cycle)
//   o_m_tdata/tvalid/tlast    output stream, i_m_tready is its back-pressure
//   o_busy                    FSM not idle
//   o_err_underrun            sticky: packet withdrawn before fully read
// Build option: TASK_ANSWER_TX_CHECKSUM_EN appends an XOR of all header and
// payload bytes as the final (tlast) byte.
module task_answer_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tanswer_ready,
    input  logic [SIZE_WIDTH-1:0] i_packet_size_in_bytes,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    output logic                  o_tmanager_ready,
    output logic [DATA_WIDTH-1:0] o_m_tdata,
    output logic                  o_m_tvalid,
    input  logic                  i_m_tready,
    output logic                  o_m_tlast,
    output logic                  o_busy,
    output logic                  o_err_underrun
);
    import task_answer_pkg::*;

    state_t                r_state;
    logic [SIZE_WIDTH-1:0] r_size;
    logic [SIZE_WIDTH-1:0] r_issued;
    logic [SIZE_WIDTH-1:0] r_emitted;
    logic                  r_inflight;
    logic                  r_inflight_pad;
    logic                  r_inflight_last;
    logic                  r_drop;
    logic                  r_armed;
    logic                  r_err;
`ifdef TASK_ANSWER_TX_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;
`endif

    logic [DATA_WIDTH:0]   w_wr_data;
    logic [DATA_WIDTH:0]   w_rd_data;
    logic [1:0]            w_count;
    logic [1:0]            w_after_rd;
    logic                  w_buf_nonempty;
    logic                  w_rd_en;
    logic                  w_room;
    logic                  w_more;
    logic                  w_req;
    logic                  w_pad_req;
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_hdr_hi;
    logic [DATA_WIDTH-1:0] w_hdr_lo;
    logic [DATA_WIDTH-1:0] w_tdata;
    logic                  w_tvalid;
    logic                  w_tlast;

    assign w_hdr_hi = DATA_WIDTH'(r_size[SIZE_WIDTH-1:8]);
    assign w_hdr_lo = DATA_WIDTH'(r_size[7:0]);

    assign w_buf_nonempty = (w_count != 2'd0);
    assign w_rd_en        = (r_state == PAYLOAD) && w_buf_nonempty && i_m_tready;
    // Credit the byte leaving this cycle so a full-rate stream never bubbles;
    // buffered + in-flight still never exceeds two.
    assign w_after_rd = w_count - {1'b0, w_rd_en};
    assign w_room     = ({1'b0, w_after_rd} + {2'b00, r_inflight}) < 3'd2;
    assign w_more     = (r_issued < r_size);
    assign w_req      = (r_state == PAYLOAD) && w_room && w_more && i_tanswer_ready && !r_drop;
    // After an underrun the missing bytes flow through the same buffer path as
    // pad "reads", so ordering and frame length are preserved.
    assign w_pad_req  = (r_state == PAYLOAD) && w_room && w_more && (r_drop || !i_tanswer_ready);
    assign w_issue    = w_req || w_pad_req;
`ifdef TASK_ANSWER_TX_CHECKSUM_EN
    assign w_issue_last = 1'b0;
`else
    assign w_issue_last = (r_issued == (r_size - SIZE_WIDTH'(1)));
`endif

    assign w_wr_data = {r_inflight_last,
                        r_inflight_pad ? DATA_WIDTH'(PAD_BYTE) : i_tdata};

    task_answer_skid #(
        .W(DATA_WIDTH + 1)
    ) u_skid (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (r_inflight),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_rd_data),
        .o_count   (w_count)
    );

    // Output byte selection from registered state, header and buffer head.
    always_comb begin
        w_tdata  = '0;
        w_tvalid = 1'b0;
        w_tlast  = 1'b0;
        case (r_state)
            HDR_HI: begin
                w_tdata  = w_hdr_hi;
                w_tvalid = 1'b1;
            end
            HDR_LO: begin
                w_tdata  = w_hdr_lo;
                w_tvalid = 1'b1;
            end
            PAYLOAD: begin
                w_tdata  = w_rd_data[DATA_WIDTH-1:0];
                w_tvalid = w_buf_nonempty;
                w_tlast  = w_rd_data[DATA_WIDTH];
            end
`ifdef TASK_ANSWER_TX_CHECKSUM_EN
            CHK: begin
                w_tdata  = r_csum;
                w_tvalid = 1'b1;
                w_tlast  = 1'b1;
            end
`endif
            default: begin
                w_tdata  = '0;
                w_tvalid = 1'b0;
                w_tlast  = 1'b0;
            end
        endcase
    end

    assign w_xfer = w_tvalid && i_m_tready;

    // Framing FSM with packet counters, underrun tracking and re-arm gate.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= IDLE;
            r_size          <= '0;
            r_issued        <= '0;
            r_emitted       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_pad  <= 1'b0;
            r_inflight_last <= 1'b0;
            r_drop          <= 1'b0;
            r_armed         <= 1'b0;
            r_err           <= 1'b0;
`ifdef TASK_ANSWER_TX_CHECKSUM_EN
            r_csum          <= '0;
`endif
        end else begin
            // A new packet needs i_tanswer_ready to have been low since the last one.
            if (!i_tanswer_ready) begin
                r_armed <= 1'b1;
            end
            r_inflight      <= w_issue;
            r_inflight_pad  <= w_pad_req;
            r_inflight_last <= w_issue && w_issue_last;
            if (w_issue) begin
                r_issued <= r_issued + SIZE_WIDTH'(1);
            end
            case (r_state)
                IDLE: begin
                    if (i_tanswer_ready && r_armed && (i_packet_size_in_bytes != '0)) begin
                        r_size    <= i_packet_size_in_bytes;
                        r_issued  <= '0;
                        r_emitted <= '0;
                        r_drop    <= 1'b0;
                        r_armed   <= 1'b0;
`ifdef TASK_ANSWER_TX_CHECKSUM_EN
                        r_csum    <= '0;
`endif
                        r_state   <= HDR_HI;
                    end
                end
                HDR_HI, HDR_LO: begin
                    if (w_xfer) begin
`ifdef TASK_ANSWER_TX_CHECKSUM_EN
                        r_csum  <= r_csum ^ w_tdata;
`endif
                        r_state <= (r_state == HDR_HI) ? HDR_LO : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!i_tanswer_ready && w_more) begin
                        r_drop <= 1'b1;
                        r_err  <= 1'b1;
                    end
                    if (w_xfer) begin
`ifdef TASK_ANSWER_TX_CHECKSUM_EN
                        r_csum <= r_csum ^ w_tdata;
`endif
                        if (r_emitted < r_size) begin
                            r_emitted <= r_emitted + SIZE_WIDTH'(1);
                        end
                        if (r_emitted == (r_size - SIZE_WIDTH'(1))) begin
`ifdef TASK_ANSWER_TX_CHECKSUM_EN
                            r_state <= CHK;
`else
                            r_state <= DONE;
`endif
                        end
                    end
                end
`ifdef TASK_ANSWER_TX_CHECKSUM_EN
                CHK: begin
                    if (w_xfer) begin
                        r_state <= DONE;
                    end
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_tmanager_ready = w_req;
    assign o_m_tdata        = w_tdata;
    assign o_m_tvalid       = w_tvalid;
    assign o_m_tlast        = w_tlast;
    assign o_busy           = (r_state != IDLE);
    assign o_err_underrun   = r_err;

endmodule
